// File: rtl/add_sub_serial.sv
// Chunk-serial two's-complement adder/subtractor: CHUNK bits per clock, valid/ready
// on both sides, optional signed saturation, zero/negative flags on the final result.
module add_sub_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] answer,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_POS = ~MOST_NEG;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sat_q, sat_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;
  logic             z_q, z_d;
  logic             n_q, n_d;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] res_sat;
  logic             msb_cin;
  logic             raw_ovf;
  logic             last;

  // Operands shift right one chunk per cycle, so the low chunk is always the
  // current one and, on the last step, bit CHUNK-1 is the operand MSB.
  always_comb begin
    sum       = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    res_shift = (res_q >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum[CHUNK-1];
    raw_ovf   = msb_cin ^ sum[CHUNK];
    res_sat   = (sat_q && raw_ovf) ? (a_q[CHUNK-1] ? MOST_NEG : MOST_POS) : res_shift;
    last      = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    co_d    = co_q;
    ov_d    = ov_q;
    z_d     = z_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          sat_d   = sat;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          res_d   = res_sat;
          co_d    = sum[CHUNK];
          ov_d    = raw_ovf;
          z_d     = (res_sat == '0);
          n_d     = res_sat[WIDTH-1];
          state_d = S_DONE;
        end else begin
          res_d = res_shift;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign answer    = res_q;
  assign carryout  = co_q;
  assign overflow  = ov_q;
  assign zero      = z_q;
  assign negative  = n_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial over four WIDTH/CHUNK configurations, with
// directed corner cases and randomized traffic checked against an arithmetic model.
module tb_add_sub_serial;

  typedef struct packed {
    logic [31:0] ans;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } exp_t;

  localparam int WS[4] = '{16, 8, 16, 32};
  localparam int CS[4] = '{4, 8, 1, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] ans, input logic co, ov, z, n);
    exp_t e;
    e.ans = ans; e.co = co; e.ov = ov; e.z = z; e.n = n;
    return e;
  endfunction

  // Reference: exact signed/unsigned arithmetic, then wrap or clamp to w bits.
  function automatic exp_t model(input int w, input logic [63:0] ai, bi, input logic s, st);
    exp_t        e;
    logic [63:0] span, m, ua, ub, ru;
    longint      sa, sb, ex, mx, mn, r;
    span = 64'd1 << w;
    m    = span - 64'd1;
    ua   = ai & m;
    ub   = bi & m;
    sa   = ua[w-1] ? longint'(ua) - longint'(span) : longint'(ua);
    sb   = ub[w-1] ? longint'(ub) - longint'(span) : longint'(ub);
    ex   = s ? sa - sb : sa + sb;
    mx   = (longint'(1) << (w - 1)) - 1;
    mn   = -mx - 1;
    e.ov = (ex > mx) || (ex < mn);
    e.co = s ? (ua >= ub) : ((ua + ub) > m);
    r    = (st && e.ov) ? ((ex < 0) ? mn : mx) : ex;
    ru   = r;
    ru   = ru & m;
    e.ans = ru[31:0];
    e.z   = (ru == 64'd0);
    e.n   = ru[w-1];
    return e;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = WS[g];
    localparam int C = CS[g];
    localparam int N = W / C;
    localparam int G = g;

    logic         rst_n, in_valid, in_ready, sub, sat, out_valid, out_ready;
    logic         carryout, overflow, zero, negative;
    logic [W-1:0] a, b, answer;
    exp_t         q[$];
    exp_t         mon_e;
    bit           fin = 1'b0;

    add_sub_serial #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready), .answer(answer),
      .carryout(carryout), .overflow(overflow), .zero(zero), .negative(negative)
    );

    always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        chk($sformatf("cfg%0d pending", G), 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk($sformatf("cfg%0d answer", G), 32'(answer), mon_e.ans);
          chk($sformatf("cfg%0d carryout", G), 32'(carryout), 32'(mon_e.co));
          chk($sformatf("cfg%0d overflow", G), 32'(overflow), 32'(mon_e.ov));
          chk($sformatf("cfg%0d zero", G), 32'(zero), 32'(mon_e.z));
          chk($sformatf("cfg%0d negative", G), 32'(negative), 32'(mon_e.n));
        end
      end
    end

    task automatic scramble();
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      sat = 1'($urandom);
    endtask

    task automatic chk_reset(input string tag);
      chk($sformatf("cfg%0d %s in_ready", G, tag), 32'(in_ready), 32'd1);
      chk($sformatf("cfg%0d %s out_valid", G, tag), 32'(out_valid), 32'd0);
      chk($sformatf("cfg%0d %s answer", G, tag), 32'(answer), 32'd0);
      chk($sformatf("cfg%0d %s flags", G, tag), 32'({carryout, overflow, zero, negative}), 32'd0);
    endtask

    task automatic accept(input logic [W-1:0] aa, bb, input logic s, st, input exp_t e, input bit push);
      int unsigned k = 0;
      a = aa; b = bb; sub = s; sat = st; in_valid = 1'b1;
      @(negedge clk);
      while (in_ready !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("cfg%0d accept_wait", G), 32'(in_ready), 32'd1);
      if (push) q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble();
    endtask

    task automatic measure();
      int unsigned k = 0;
      out_ready = 1'b1;
      while (out_valid !== 1'b1 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      chk($sformatf("cfg%0d latency", G), k, 32'(N));
    endtask

    task automatic drain(input bit rnd);
      int unsigned k = 0;
      while (q.size() > 0 && k < 500) begin
        out_ready = rnd ? 1'($urandom) : 1'b1;
        if (rnd) begin
          scramble();
          in_valid = 1'($urandom);
        end
        @(posedge clk); #1;
        k++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk($sformatf("cfg%0d drain", G), 32'(q.size()), 32'd0);
    endtask

    task automatic reset_seq();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0; sat = 1'b0;
      #1 rst_n = 1'b0;
      #2 chk_reset("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
        0: v = '0;
        1: v = '1;
        2: begin v = '0; v[W-1] = 1'b1; end
        3: begin v = '1; v[W-1] = 1'b0; end
        default: v = W'($urandom);
      endcase
      return v;
    endfunction

    task automatic random_phase();
      logic [W-1:0] aa, bb;
      logic         s, st;
      repeat (40) begin
        aa = pick(); bb = pick(); s = 1'($urandom); st = 1'($urandom);
        accept(aa, bb, s, st, model(W, 64'(aa), 64'(bb), s, st), 1'b1);
        drain(1'b1);
      end
    endtask

    if (g == 0) begin : dir
      initial begin
        int unsigned k;
        reset_seq();
        accept(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(32'h8000, 0, 1, 0, 1), 1'b1);
        measure();
        drain(1'b0);
        accept(16'h7FFF, 16'h0001, 1'b0, 1'b1, mk(32'h7FFF, 0, 1, 0, 0), 1'b1);
        drain(1'b0);
        accept(16'h8000, 16'h0001, 1'b1, 1'b1, mk(32'h8000, 1, 1, 0, 1), 1'b1);
        drain(1'b0);
        accept(16'h0005, 16'h0007, 1'b1, 1'b0, mk(32'hFFFE, 0, 0, 0, 1), 1'b1);
        drain(1'b0);
        accept(16'h1234, 16'h1234, 1'b1, 1'b0, mk(32'h0000, 1, 0, 1, 0), 1'b1);
        drain(1'b0);

        // Held result with operand churn during RUN and a pending request in DONE.
        out_ready = 1'b0;
        accept(16'h1111, 16'h2222, 1'b0, 1'b0, mk(32'h3333, 0, 0, 0, 0), 1'b1);
        k = 0;
        while (out_valid !== 1'b1 && k < 100) begin
          scramble();
          @(posedge clk); #1;
          k++;
        end
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0; sat = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("cfg0 hold answer", 32'(answer), 32'h3333);
          chk("cfg0 hold flags", 32'({carryout, overflow, zero, negative}), 32'd0);
          chk("cfg0 hold out_valid", 32'(out_valid), 32'd1);
          chk("cfg0 hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("cfg0 post_done in_ready", 32'(in_ready), 32'd1);
        chk("cfg0 post_done out_valid", 32'(out_valid), 32'd0);
        q.push_back(mk(32'h0002, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("cfg0 late_accept in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        drain(1'b0);

        // Abort in the second RUN cycle.
        accept(16'h4321, 16'h1111, 1'b0, 1'b0, mk(32'h0, 0, 0, 0, 0), 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 chk_reset("abort");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(32'h0100, 0, 0, 0, 0), 1'b1);
        drain(1'b0);

        random_phase();
        chk("cfg0 queue_empty", 32'(q.size()), 32'd0);
        fin = 1'b1;
      end
    end else if (g == 1) begin : dir
      initial begin
        reset_seq();
        accept(8'hFF, 8'h01, 1'b0, 1'b0, mk(32'h00, 1, 0, 1, 0), 1'b1);
        measure();
        drain(1'b0);
        random_phase();
        chk("cfg1 queue_empty", 32'(q.size()), 32'd0);
        fin = 1'b1;
      end
    end else begin : rnd
      initial begin
        reset_seq();
        random_phase();
        chk($sformatf("cfg%0d queue_empty", G), 32'(q.size()), 32'd0);
        fin = 1'b1;
      end
    end
  end

  initial begin
    int unsigned t = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    chk("all_done", 32'(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised, chunk-serial two's-complement adder/subtractor. It is the multi-cycle successor to the 8-bit ripple add/sub. A WIDTH-bit operation is processed CHUNK bits per clock, with optional signed saturation and zero/negative flags. Operands enter and results leave through valid/ready handshakes, so the block sits between the register-file read stage and the writeback path of the datapath.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- sat  input  1  1 = saturate the signed result on overflow.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- answer  output  WIDTH  result.
- carryout  output  1  carry out of the MSB; for subtraction, 1 = no borrow (A ≥ B unsigned).
- overflow  output  1  raw signed overflow, defined as carry into MSB XOR carry out of MSB.
- zero  output  1  answer == 0, evaluated after saturation.
- negative  output  1  answer[WIDTH-1], evaluated after saturation.

## Operation
- The FSM has three states: IDLE, RUN and DONE. The reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, the block captures a, b^{WIDTH{sub}}, sub and sat.
  - The internal carry is initialised to sub, the chunk counter to 0, and the FSM moves to RUN.
- RUN:
  - Each cycle, chunk k (bits k·CHUNK .. k·CHUNK+CHUNK−1) is added with the running carry and written into the result register.
  - The carry is updated and k increments.
  - For the last chunk (k = N−1), the carry into the MSB and the carry out of the MSB are recorded, and the FSM moves to DONE.
- Saturation is applied on entry to DONE, only when sat = 1 and overflow = 1:
  - answer = 1 followed by zeros (most negative) if A[WIDTH-1] = 1.
  - answer = 0 followed by ones (most positive) otherwise.
  - overflow still reports the raw overflow. carryout is not altered.
- DONE:
  - out_valid = 1. answer and all flags are held stable.
  - On out_ready, the FSM returns to IDLE.
- in_ready = 0 in RUN and DONE. Changes to a, b, sub, sat or in_valid outside the IDLE accept cycle have no effect.
- Arithmetic is modulo 2^WIDTH. No internal width grows beyond WIDTH+1 bits per chunk sum.

## Timing
- Reset values while rst_n is low: in_ready = 1, out_valid = 0, answer = 0, carryout = 0, overflow = 0, zero = 0, negative = 0. The FSM is in IDLE and the counter is 0.
- Latency: if the accept edge is cycle 0, out_valid rises after edge N.
- Minimum occupancy is N+2 cycles per operation:
  - 1 cycle in IDLE (accept),
  - N cycles in RUN,
  - at least 1 cycle in DONE.
- DONE → IDLE transitions on the edge where out_ready = 1. in_ready is 1 on the following cycle. There is no accept in the same cycle as result consumption.
- out_ready held low: the block stays in DONE indefinitely with all outputs frozen.
- out_ready high before out_valid: ignored.
- CHUNK = WIDTH (N = 1): the block passes through exactly one RUN cycle.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately (asynchronously) and all outputs take their reset values. The first operation after rst_n deasserts must be correct.
- Outputs answer and the flags are registered. in_ready and out_valid are decoded directly from the state register.

## Test plan
- WIDTH=16, CHUNK=4, add, sat=0, 0x7FFF + 0x0001 → answer 0x8000, overflow=1, carryout=0, negative=1, zero=0; out_valid rises exactly 4 edges after accept.
- Same operands with sat=1 → answer 0x7FFF, overflow=1, negative=0. Sub with sat=1, 0x8000 − 0x0001 → answer 0x8000, overflow=1, carryout=1.
- Sub, sat=0:
  - 0x0005 − 0x0007 → 0xFFFE, carryout=0, negative=1.
  - 0x1234 − 0x1234 → 0x0000, zero=1, carryout=1, overflow=0.
- Handshake: hold out_ready=0 for 3 cycles after out_valid.
  - answer and flags stay stable and in_ready stays 0.
  - Toggling a/b/sub during RUN does not change the result.
  - The next in_valid is accepted only after DONE → IDLE.
- Reset: assert rst_n=0 during the 2nd RUN cycle → all outputs immediately at reset values and in_ready=1. After release, 0x00FF + 0x0001 → 0x0100 with no flags set.
- WIDTH=8, CHUNK=8: 0xFF + 0x01 → 0x00, carryout=1, zero=1, overflow=0; out_valid 1 edge after accept. Random regression checks against a reference model for (16,4), (16,1) and (32,8).
